// File: rtl/mole_game_if.sv
// Game I/O bundle: start and switch inputs in, mole LEDs and score/time display values out.
// The engine connects through the slave modport; the board or bench drives the master side.
interface mole_game_if #(
  parameter int N_HOLES = 16,
  parameter int SCORE_W = 8,
  parameter int TIME_W  = 8
);
  logic               start;
  logic [N_HOLES-1:0] sw;
  logic [N_HOLES-1:0] LED;
  logic [SCORE_W-1:0] score;
  logic [TIME_W-1:0]  time_left;
  logic               playing;
  logic               game_over;

  modport master (
    output start, sw,
    input  LED, score, time_left, playing, game_over
  );

  modport slave (
    input  start, sw,
    output LED, score, time_left, playing, game_over
  );
endinterface

// File: rtl/mole_game_engine.sv
// Whack-a-mole core: game timer, no-repeat mole placement, whack detection and saturating score.
// Every output comes straight from a register, so switch inputs never reach an output combinationally.
module mole_game_engine #(
  parameter int          N_HOLES      = 16,
  parameter int          CLK_HZ       = 100000000,
  parameter int          GAME_SECONDS = 30,
  parameter int          MOLE_CYCLES  = 75000000,
  parameter int          GAP_CYCLES   = 25000000,
  parameter int          SCORE_W      = 8,
  parameter int          TIME_W       = 8,
  parameter int          MISS_PENALTY = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  mole_game_if.slave bus
);
  localparam int HOLE_W = $clog2(N_HOLES);
  localparam int SEC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int MOLE_W = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, OVER} state_t;

  state_t             state, next_state;
  logic [15:0]        lfsr, lfsr_nxt;
  logic [N_HOLES-1:0] sw_p0, sw_p1, sw_p2;
  logic [N_HOLES-1:0] led, led_nxt;
  logic [SCORE_W-1:0] score, score_nxt;
  logic [TIME_W-1:0]  time_left, time_nxt;
  logic               playing, playing_nxt;
  logic               game_over, game_over_nxt;
  logic [SEC_W-1:0]   sec_cnt, sec_nxt;
  logic [MOLE_W-1:0]  mole_cnt, mole_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [HOLE_W-1:0]  prev_hole, prev_nxt;
  logic [HOLE_W-1:0]  idx, hole;
  logic [N_HOLES-1:0] strike;
  logic               hit, miss, active, tick, game_end, mole_done, gap_done;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
    return (v == '0) ? v : v - SCORE_W'(1);
  endfunction

  // Galois form, taps 16,14,13,11
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // A repeat of the previous hole is nudged to its neighbour so the same mole never appears twice running
  assign idx  = HOLE_W'(lfsr[7:0] % 8'(N_HOLES));
  assign hole = (idx != prev_hole) ? idx :
                (idx == HOLE_W'(N_HOLES - 1)) ? '0 : idx + HOLE_W'(1);

  // Either switch direction counts as a strike
  assign strike    = sw_p1 ^ sw_p2;
  assign hit       = |(strike & led);
  assign miss      = |(strike & ~led);
  assign active    = (state == SPAWN) || (state == UP) || (state == GAP);
  assign tick      = active && (sec_cnt == SEC_W'(CLK_HZ - 1));
  assign game_end  = tick && (time_left == TIME_W'(1));
  assign mole_done = (mole_cnt == MOLE_W'(MOLE_CYCLES - 1));
  assign gap_done  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, OVER: if (bus.start) next_state = SPAWN;
      SPAWN:      next_state = game_end ? OVER : UP;
      UP: begin
        if (game_end)              next_state = OVER;
        else if (hit || mole_done) next_state = GAP;
      end
      GAP: begin
        if (game_end)      next_state = OVER;
        else if (gap_done) next_state = SPAWN;
      end
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    led_nxt       = led;
    score_nxt     = score;
    time_nxt      = time_left;
    sec_nxt       = sec_cnt;
    mole_nxt      = mole_cnt;
    gap_nxt       = gap_cnt;
    prev_nxt      = prev_hole;
    playing_nxt   = (next_state == SPAWN) || (next_state == UP) || (next_state == GAP);
    game_over_nxt = (next_state == OVER);
    if (active) begin
      sec_nxt = tick ? '0 : sec_cnt + SEC_W'(1);
      if (tick) time_nxt = time_left - TIME_W'(1);
    end
    unique case (state)
      IDLE, OVER: begin
        if (bus.start) begin
          score_nxt = '0;
          time_nxt  = TIME_W'(GAME_SECONDS);
          sec_nxt   = '0;
        end
      end
      SPAWN: begin
        if (!game_end) begin
          led_nxt  = N_HOLES'(1) << hole;
          prev_nxt = hole;
          mole_nxt = '0;
        end
      end
      UP: begin
        mole_nxt = mole_cnt + MOLE_W'(1);
        // Game end wins over anything struck on the same edge
        if (game_end) begin
          led_nxt = '0;
        end else if (hit) begin
          score_nxt = sat_inc(score);
          led_nxt   = '0;
          gap_nxt   = '0;
        end else begin
          if (miss && (MISS_PENALTY != 0)) score_nxt = sat_dec(score);
          if (mole_done) begin
            led_nxt = '0;
            gap_nxt = '0;
          end
        end
      end
      GAP:     gap_nxt = gap_cnt + GAP_W'(1);
      default: led_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= LFSR_SEED;
      sw_p0     <= '0;
      sw_p1     <= '0;
      sw_p2     <= '0;
      led       <= '0;
      score     <= '0;
      time_left <= TIME_W'(GAME_SECONDS);
      playing   <= 1'b0;
      game_over <= 1'b0;
      sec_cnt   <= '0;
      mole_cnt  <= '0;
      gap_cnt   <= '0;
      prev_hole <= '0;
    end else begin
      lfsr      <= lfsr_nxt;
      sw_p0     <= bus.sw;
      sw_p1     <= sw_p0;
      sw_p2     <= sw_p1;
      led       <= led_nxt;
      score     <= score_nxt;
      time_left <= time_nxt;
      playing   <= playing_nxt;
      game_over <= game_over_nxt;
      sec_cnt   <= sec_nxt;
      mole_cnt  <= mole_nxt;
      gap_cnt   <= gap_nxt;
      prev_hole <= prev_nxt;
    end
  end

  assign bus.LED       = led;
  assign bus.score     = score;
  assign bus.time_left = time_left;
  assign bus.playing   = playing;
  assign bus.game_over = game_over;
endmodule

// File: tb/tb_mole_game_engine.sv
// Bench for mole_game_engine: 100-cycle seconds, 3 s games, 20-cycle moles, 5-cycle gaps,
// miss penalty on and a 2-bit score so saturation is reachable.
module tb_mole_game_engine;
  localparam int NH = 16;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   spawns = 0;
  int   q[$];

  always #5 clk = ~clk;

  mole_game_if #(.N_HOLES(NH), .SCORE_W(SW), .TIME_W(8)) bus ();

  mole_game_engine #(
    .N_HOLES(NH), .CLK_HZ(100), .GAME_SECONDS(3), .MOLE_CYCLES(20), .GAP_CYCLES(5),
    .SCORE_W(SW), .TIME_W(8), .MISS_PENALTY(1), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hole_of(input logic [NH-1:0] v);
    for (int i = 0; i < NH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_lit();
    int n = 0;
    while (bus.LED == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.LED == '0) check("wait_lit_timeout", 0, 1);
  endtask

  task automatic wait_over();
    int n = 0;
    while (!bus.game_over && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.game_over) check("wait_over_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Score monitor: every change of score must match the next queued expectation
  initial begin : score_mon
    logic [SW-1:0] last = '0;
    forever begin
      @(negedge clk);
      if (bus.score !== last) begin
        if (q.size() == 0) check("score_unexpected", int'(bus.score), int'(last));
        else check("score_sb", int'(bus.score), q.pop_front());
        last = bus.score;
      end
    end
  end

  // LED monitor: each new mole is one-hot and never on the previous hole
  initial begin : led_mon
    int last_hole = 0;
    logic prev_lit = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_hole = 0;
        prev_lit  = 1'b0;
      end else begin
        if (!prev_lit && bus.LED != '0) begin
          check("led_onehot", $countones(bus.LED), 1);
          check("no_repeat", int'(hole_of(bus.LED) == last_hole), 0);
          last_hole = hole_of(bus.LED);
          spawns++;
        end
        prev_lit = (bus.LED != '0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int h, w, dark, lit_run, g;
    logic prev_lit, seen_lit;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.sw = '0;
    repeat (3) @(negedge clk);
    check("rst_led", int'(bus.LED), 0);
    check("rst_score", int'(bus.score), 0);
    check("rst_time", int'(bus.time_left), 3);
    check("rst_playing", int'(bus.playing), 0);
    check("rst_over", int'(bus.game_over), 0);
    reset = 1'b0;
    @(negedge clk);

    // Game 1: start, hit latency, gap length, miss penalty
    pulse_start();
    check("start_playing", int'(bus.playing), 1);
    check("start_score", int'(bus.score), 0);
    check("start_time", int'(bus.time_left), 3);
    check("spawn_dark", int'(bus.LED), 0);
    @(negedge clk);
    check("first_led_onehot", $countones(bus.LED), 1);
    h = hole_of(bus.LED);
    repeat (4) @(negedge clk);
    bus.sw[h] = ~bus.sw[h];
    q.push_back(1);
    repeat (2) @(negedge clk);
    check("hit_not_early", int'(bus.score), 0);
    @(negedge clk);
    check("hit_score", int'(bus.score), 1);
    check("hit_led_clear", int'(bus.LED), 0);
    bus.sw[(h + 3) % NH] = ~bus.sw[(h + 3) % NH];
    dark = 1;
    while (bus.LED == '0 && dark < 50) begin
      @(negedge clk);
      if (bus.LED == '0) dark++;
    end
    check("dark_after_hit", dark, 6);

    h = hole_of(bus.LED);
    bus.sw[h] = ~bus.sw[h];
    q.push_back(2);
    repeat (3) @(negedge clk);
    check("hit2_score", int'(bus.score), 2);
    wait_lit();

    h = hole_of(bus.LED);
    w = (h + 1) % NH;
    bus.sw[w] = ~bus.sw[w];
    q.push_back(1);
    repeat (3) @(negedge clk);
    check("miss_score", int'(bus.score), 1);
    check("miss_led_kept", int'(bus.LED == (NH'(1) << h)), 1);
    bus.sw[w] = ~bus.sw[w];
    q.push_back(0);
    repeat (3) @(negedge clk);
    check("miss2_score", int'(bus.score), 0);
    bus.sw[w] = ~bus.sw[w];
    repeat (3) @(negedge clk);
    check("miss_floor", int'(bus.score), 0);
    check("miss_floor_led", int'(bus.LED == (NH'(1) << h)), 1);
    bus.sw[w] = ~bus.sw[w];
    bus.sw[h] = ~bus.sw[h];
    q.push_back(1);
    repeat (3) @(negedge clk);
    check("hit_and_miss", int'(bus.score), 1);
    check("hit_and_miss_led", int'(bus.LED), 0);

    wait_over();
    check("over_led", int'(bus.LED), 0);
    check("over_time", int'(bus.time_left), 0);
    check("over_playing", int'(bus.playing), 0);
    bus.sw[3:0] = ~bus.sw[3:0];
    repeat (5) @(negedge clk);
    check("over_strike_score", int'(bus.score), 1);
    check("over_strike_led", int'(bus.LED), 0);
    check("over_held", int'(bus.game_over), 1);

    // Game 2: restart from OVER, untouched timing, start while playing ignored
    q.push_back(0);
    pulse_start();
    check("restart_score", int'(bus.score), 0);
    check("restart_time", int'(bus.time_left), 3);
    check("restart_playing", int'(bus.playing), 1);
    check("restart_over", int'(bus.game_over), 0);
    prev_lit = 1'b0;
    seen_lit = 1'b0;
    dark = 1;
    lit_run = 0;
    for (int k = 2; k <= 301; k++) begin
      bus.start = (k == 150);
      @(negedge clk);
      if (bus.LED != '0) begin
        if (!prev_lit) begin
          if (seen_lit) check("gap_len", dark, 6);
          seen_lit = 1'b1;
          lit_run = 0;
        end
        lit_run++;
      end else begin
        if (prev_lit) begin
          if (!bus.game_over) check("mole_len", lit_run, 20);
          dark = 0;
        end
        dark++;
      end
      prev_lit = (bus.LED != '0);
      if (k == 100) check("time_t99", int'(bus.time_left), 3);
      if (k == 101) check("time_t100", int'(bus.time_left), 2);
      if (k == 151) check("start_ignored_time", int'(bus.time_left), 2);
      if (k == 201) check("time_t200", int'(bus.time_left), 1);
      if (k == 300) check("not_over_yet", int'(bus.game_over), 0);
      if (k == 301) begin
        check("time_t300", int'(bus.time_left), 0);
        check("end_over", int'(bus.game_over), 1);
        check("end_led", int'(bus.LED), 0);
      end
    end
    bus.start = 1'b0;

    // Further idle games to gather enough spawns
    g = 0;
    while (spawns < 50 && g < 8) begin
      pulse_start();
      wait_over();
      g++;
    end
    check("spawn_count_50", int'(spawns >= 50), 1);

    // Saturation at 3 with a 2-bit score, then async reset mid-mole
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_lit();
      h = hole_of(bus.LED);
      bus.sw[h] = ~bus.sw[h];
      if (i < 3) q.push_back(i + 1);
      repeat (3) @(negedge clk);
      check("sat_score", int'(bus.score), (i < 3) ? i + 1 : 3);
    end
    wait_lit();
    repeat (3) @(negedge clk);
    q.push_back(0);
    #2 reset = 1'b1;
    #1;
    check("async_led", int'(bus.LED), 0);
    check("async_score", int'(bus.score), 0);
    check("async_time", int'(bus.time_left), 3);
    check("async_playing", int'(bus.playing), 0);
    check("async_over", int'(bus.game_over), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mole_game_engine.md
Name: mole_game_engine

Overview:
- Parametrised whack-a-mole game core: owns game timer, mole placement, whack detection and scoring for N_HOLES switch/LED pairs.
- Feeds the existing bin_to_bcd / 7-segment display path via score and time_left.
- Adds start/game-over sequencing, no-repeat hole selection, fixed mole lifetime and optional miss penalty.

Parameters:
- N_HOLES, 16, number of switch/LED holes (2..32).
- CLK_HZ, 100000000, input clock frequency; one second equals CLK_HZ cycles.
- GAME_SECONDS, 30, game length in seconds; must be < 2^TIME_W.
- MOLE_CYCLES, 75000000, clocks a mole stays lit.
- GAP_CYCLES, 25000000, dark clocks between moles.
- SCORE_W, 8, score width.
- TIME_W, 8, time_left width.
- MISS_PENALTY, 0, 1 means a wrong-hole strike subtracts 1 from score.
- LFSR_SEED, 16'hACE1, nonzero seed of the 16-bit Galois LFSR (taps 16,14,13,11).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high; clears all state.
- start, input, 1, synchronous pulse/level that starts a game.
- sw, input, N_HOLES, raw slide switches, asynchronous to clk.
- LED, output, N_HOLES, one-hot lit mole or all zero.
- score, output, SCORE_W, current or final score.
- time_left, output, TIME_W, seconds remaining.
- playing, output, 1, high in SPAWN/UP/GAP.
- game_over, output, 1, high in OVER.

Behaviour:
- Reset values: state IDLE, LED 0, score 0, time_left GAME_SECONDS, playing 0, game_over 0, LFSR LFSR_SEED, all counters 0, prev_hole 0.
- sw passes through a 2-flop synchroniser plus a registered copy. strike[i] = sync[i] XOR sync_d[i], so either toggle direction counts. A change on sw reaches the score register 3 clocks later.
- The LFSR advances every clock in all states.
- States and transitions:
  - IDLE: when start is high, go to SPAWN, clear score, load time_left = GAME_SECONDS, clear the second counter.
  - SPAWN (1 cycle): idx = LFSR[7:0] mod N_HOLES. If idx == prev_hole, use (idx+1) mod N_HOLES. Light LED[idx], store prev_hole, clear the mole counter, go to UP.
  - UP: a strike on the lit hole is a hit. Score +1, saturating at 2^SCORE_W-1. Clear LED and go to GAP next cycle. When the mole counter reaches MOLE_CYCLES-1 with no hit, clear LED and go to GAP.
  - UP, wrong-hole strike: any strike not on the lit hole is a miss. If MISS_PENALTY=1, score -1, saturating at 0. The mole stays lit.
  - UP, simultaneous hit and miss in one cycle: only the hit counts; no penalty is applied.
  - GAP: LED 0 and strikes are ignored. After GAP_CYCLES clocks, go to SPAWN.
  - OVER: LED 0, score and time_left held, game_over 1. When start is high, restart exactly as from IDLE.
- Second counter: runs only in SPAWN/UP/GAP. It wraps at CLK_HZ-1 and emits a 1-cycle tick; on each tick time_left decrements.
- End of game: when a tick brings time_left to 0, go to OVER on that same edge. This overrides any hit or miss evaluated in that cycle, with no score change; LED is cleared.
- start while playing: ignored.
- Reset asserted mid-game: immediate return to reset values, with no clock edge needed.
- Counters are sized with $clog2 of their terminal value. No combinational path exists from sw to any output; all outputs are registered.

Test Plan (bench params: CLK_HZ=100, GAME_SECONDS=3, MOLE_CYCLES=20, GAP_CYCLES=5, N_HOLES=16):
1. Reset, then start pulse -> playing=1, score=0, time_left=3; exactly one LED bit set 2 cycles after start; no two consecutive moles on the same hole over 50 spawns.
2. Toggle sw of the lit hole 5 cycles into UP -> score goes 0→1 three clocks after the toggle; LED goes 0 next cycle; the next mole lights 5 GAP cycles later.
3. MISS_PENALTY=1: wrong-hole toggle at score 2 -> score 1, mole still lit; wrong toggle at score 0 -> score stays 0. Hit and wrong toggle on the same edge -> +1 only.
4. No strikes -> each mole lit exactly 20 cycles, gap exactly 5. time_left reads 3,2,1,0 at 100-cycle intervals; game_over=1 and LED=0 at 300 cycles.
5. Strikes during OVER and start during play -> no effect. start in OVER -> score 0, time_left 3, new game begins.
6. Score saturation with SCORE_W=2 -> 4th hit leaves score at 3. Async reset pulsed between clock edges mid-UP -> all outputs take reset values immediately.
